bram_burst_reader: RTL and testbench



---
 rtl/bram_burst_reader_if.sv | 26 ++
 rtl/bram_burst_reader.sv | 119 +++++++++++
 tb/tb_bram_burst_reader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_burst_reader_if.sv
// Request, BRAM-read and beat-stream signals of the instruction-cache line-fill engine.
// The slave modport is the burst reader; the master modport is its environment.
interface bram_burst_reader_if #(
   parameter int BRAM_AW = 13
);
   logic               req_valid;
   logic [31:0]        req_addr;
   logic               req_ready;
   logic               busy;
   logic               bram_en;
   logic [BRAM_AW-1:0] bram_addr;
   logic [31:0]        bram_rdata;
   logic [31:0]        out_data;
   logic               out_valid;
   logic               fill_done;

   modport slave (
      input  req_valid, req_addr, bram_rdata,
      output req_ready, busy, bram_en, bram_addr, out_data, out_valid, fill_done
   );

   modport master (
      output req_valid, req_addr, bram_rdata,
      input  req_ready, busy, bram_en, bram_addr, out_data, out_valid, fill_done
   );
endinterface

// File: rtl/bram_burst_reader.sv
// Line-fill engine: issues one cache line of BRAM reads and streams the words back as beats.
// Optional macro CRITICAL_WORD_FIRST_EN starts the burst at the missed word, wrapping in the line.
module bram_burst_reader #(
   parameter int LINE_WORDS = 8,
   parameter int RD_LAT     = 10,
   parameter int BRAM_AW    = 13
) (
   input logic                 clk,
   input logic                 rst_n,
   bram_burst_reader_if.slave  bus
);
   localparam int OW   = $clog2(LINE_WORDS);
   localparam int CW   = OW + 1;
   localparam int LNW  = BRAM_AW - OW;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [CW-1:0] LAST_CNT = CW'(LINE_WORDS - 1);

   logic [1:0]        state_q, state_d;
   logic [LNW-1:0]    line_q, line_d;
   logic [OW-1:0]     start_q, start_d;
   logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
   logic [CW-1:0]     ret_cnt_q, ret_cnt_d;
   logic [RD_LAT-1:0] sr_q, sr_d;
   logic [31:0]       out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;

   logic              issue;
   logic              last_beat;
   logic [OW-1:0]     off;
   logic              unused_addr;

   assign issue     = (state_q == S_ISSUE);
   assign off       = start_q + issue_cnt_q[OW-1:0];
   assign last_beat = out_valid_q && (ret_cnt_q == LAST_CNT);

   // Only the line and word-offset slices of the request address matter.
   assign unused_addr = ^bus.req_addr;

   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      start_d     = start_q;
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;

      // The tail of the issue-strobe pipe marks the cycle the BRAM word is valid.
      sr_d        = sr_q << 1;
      sr_d[0]     = issue;
      out_valid_d = sr_q[RD_LAT-1];
      out_data_d  = sr_q[RD_LAT-1] ? bus.bram_rdata : out_data_q;

      if (out_valid_q) begin
         ret_cnt_d = ret_cnt_q + CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               line_d      = bus.req_addr[BRAM_AW+1:OW+2];
`ifdef CRITICAL_WORD_FIRST_EN
               start_d     = bus.req_addr[OW+1:2];
`else
               start_d     = '0;
`endif
               issue_cnt_d = '0;
               ret_cnt_d   = '0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            issue_cnt_d = issue_cnt_q + CW'(1);
            if (issue_cnt_q == LAST_CNT) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Leave on the final beat so IDLE follows it directly.
            if (last_beat) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         line_q      <= '0;
         start_q     <= '0;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
         sr_q        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         start_q     <= start_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
         sr_q        <= sr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.req_ready = rst_n && (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.bram_en   = issue;
   assign bus.bram_addr = issue ? {line_q, off} : '0;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.fill_done = last_beat;
endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader: default instance (8 words, latency 10) and a
// small instance (4 words, latency 1), each fed by a BRAM model with mem[i] = i.
module tb_bram_burst_reader;
   localparam int LW  = 8;
   localparam int RL  = 10;
   localparam int AW  = 13;
   localparam int LW2 = 4;
   localparam int RL2 = 1;

`ifdef CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   tests_run    = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   bram_burst_reader_if #(.BRAM_AW(AW)) bus ();
   bram_burst_reader_if #(.BRAM_AW(AW)) bus2 ();

   bram_burst_reader #(.LINE_WORDS(LW), .RD_LAT(RL), .BRAM_AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   bram_burst_reader #(.LINE_WORDS(LW2), .RD_LAT(RL2), .BRAM_AW(AW)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   // BRAM models: the address presented in cycle c comes back as data in cycle c+latency.
   logic [AW-1:0] pipe  [RL];
   logic [AW-1:0] pipe2 [RL2];

   always_ff @(posedge clk) begin
      pipe[0] <= bus.bram_addr;
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
      pipe2[0] <= bus2.bram_addr;
      for (int i = 1; i < RL2; i++) pipe2[i] <= pipe2[i-1];
   end

   assign bus.bram_rdata  = {19'd0, pipe[RL-1]};
   assign bus2.bram_rdata = {19'd0, pipe2[RL2-1]};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.req_valid  = 1'b0;
      bus.req_addr   = '0;
      bus2.req_valid = 1'b0;
      bus2.req_addr  = '0;
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.req_ready); end
      tests_run++;
      if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
      tests_run++;
      if (bus.bram_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_en: got %b expected 0", bus.bram_en); end
      tests_run++;
      if (bus.bram_addr !== '0) begin tests_failed++; $display("[TB] FAIL reset_addr: got %h expected 0", bus.bram_addr); end
      tests_run++;
      if (bus.out_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h expected 0", bus.out_data); end
      tests_run++;
      if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid); end
      tests_run++;
      if (bus.fill_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", bus.fill_done); end
      step();
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 50; c++) begin
         step();
         tests_run++;
         if (bus.req_ready !== 1'b1 || bus.bram_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_c%0d: got ready=%b en=%b valid=%b busy=%b expected 1 0 0 0",
                     c, bus.req_ready, bus.bram_en, bus.out_valid, bus.busy);
         end
      end
   endtask

   task automatic test_line_fill(input logic [31:0] addr, input bit cwf, input logic [31:0] first_word, input string name);
      logic [9:0]    line;
      logic [2:0]    start;
      logic [2:0]    o;
      logic          exp_en, exp_ov;
      logic [AW-1:0] exp_addr;
      logic [31:0]   exp_data;
      line  = addr[14:5];
      start = cwf ? addr[4:2] : 3'd0;
      bus.req_addr  = addr;
      bus.req_valid = 1'b1;
      tests_run++;
      if (bus.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s_accept: got ready=%b expected 1", name, bus.req_ready); end
      for (int cyc = 1; cyc <= 21; cyc++) begin
         step();
         bus.req_valid = 1'b0;
         exp_en   = (cyc >= 1) && (cyc <= 8);
         o        = 3'(int'(start) + cyc - 1);
         exp_addr = exp_en ? {line, o} : '0;
         exp_ov   = (cyc >= 12) && (cyc <= 19);
         o        = 3'(int'(start) + ((cyc > 19) ? 7 : cyc - 12));
         exp_data = {19'd0, line, o};
         tests_run++;
         if (bus.bram_en !== exp_en || bus.bram_addr !== exp_addr) begin
            tests_failed++;
            $display("[TB] FAIL %s_issue_c%0d: got en=%b addr=%h expected en=%b addr=%h", name, cyc, bus.bram_en, bus.bram_addr, exp_en, exp_addr);
         end
         tests_run++;
         if (bus.out_valid !== exp_ov || bus.fill_done !== (cyc == 19)) begin
            tests_failed++;
            $display("[TB] FAIL %s_beat_c%0d: got valid=%b done=%b expected valid=%b done=%b", name, cyc, bus.out_valid, bus.fill_done, exp_ov, (cyc == 19));
         end
         if (cyc >= 12) begin
            tests_run++;
            if (bus.out_data !== exp_data) begin
               tests_failed++;
               $display("[TB] FAIL %s_data_c%0d: got %h expected %h", name, cyc, bus.out_data, exp_data);
            end
         end
         if (cyc == 12) begin
            tests_run++;
            if (bus.out_data !== first_word) begin
               tests_failed++;
               $display("[TB] FAIL %s_first_word: got %h expected %h", name, bus.out_data, first_word);
            end
         end
         tests_run++;
         if (bus.busy !== (cyc <= 19) || bus.req_ready !== (cyc >= 20)) begin
            tests_failed++;
            $display("[TB] FAIL %s_status_c%0d: got busy=%b ready=%b expected busy=%b ready=%b", name, cyc, bus.busy, bus.req_ready, (cyc <= 19), (cyc >= 20));
         end
      end
   endtask

   task automatic test_back_to_back();
      int accepts;
      int first_acc;
      int second_acc;
      int beats;
      accepts    = 0;
      first_acc  = -1;
      second_acc = -1;
      beats      = 0;
      bus.req_addr  = 32'h0000_0120;
      bus.req_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) step();
         if (bus.out_valid === 1'b1) beats++;
         if (bus.req_valid && bus.req_ready === 1'b1) begin
            accepts++;
            if (first_acc < 0) first_acc = c;
            else if (second_acc < 0) second_acc = c;
         end
         if (c >= 1 && c <= 19) begin
            tests_run++;
            if (bus.req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_ready_c%0d: got %b expected 0", c, bus.req_ready); end
         end
         if (c == 39) bus.req_valid = 1'b0;
      end
      tests_run++;
      if (accepts != 2 || first_acc != 0 || second_acc != 20) begin
         tests_failed++;
         $display("[TB] FAIL b2b_accepts: got %0d at %0d,%0d expected 2 at 0,20", accepts, first_acc, second_acc);
      end
      tests_run++;
      if (beats != 16) begin tests_failed++; $display("[TB] FAIL b2b_beats: got %0d expected 16", beats); end
      step();
   endtask

   task automatic test_reset_mid_burst();
      int stray;
      stray = 0;
      bus.req_addr  = 32'h0000_0120;
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      for (int c = 2; c <= 5; c++) step();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.bram_en !== 1'b0 || bus.bram_addr !== '0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL midrst_outputs: got en=%b addr=%h busy=%b ready=%b expected 0 0 0 0", bus.bram_en, bus.bram_addr, bus.busy, bus.req_ready);
      end
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.fill_done !== 1'b0 || bus.out_data !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL midrst_stream: got valid=%b done=%b data=%h expected 0 0 0", bus.out_valid, bus.fill_done, bus.out_data);
      end
      #2 rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.out_valid !== 1'b0) stray++;
      end
      tests_run++;
      if (stray != 0) begin tests_failed++; $display("[TB] FAIL midrst_stray_beats: got %0d expected 0", stray); end
   endtask

   task automatic test_small_config();
      logic          exp_en, exp_ov;
      logic [AW-1:0] exp_addr;
      bus2.req_addr  = 32'h0000_0120;
      bus2.req_valid = 1'b1;
      tests_run++;
      if (bus2.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL small_accept: got %b expected 1", bus2.req_ready); end
      for (int cyc = 1; cyc <= 8; cyc++) begin
         step();
         bus2.req_valid = 1'b0;
         exp_en   = (cyc >= 1) && (cyc <= 4);
         exp_addr = exp_en ? AW'(32'h48 + cyc - 1) : '0;
         exp_ov   = (cyc >= 3) && (cyc <= 6);
         tests_run++;
         if (bus2.bram_en !== exp_en || bus2.bram_addr !== exp_addr) begin
            tests_failed++;
            $display("[TB] FAIL small_issue_c%0d: got en=%b addr=%h expected en=%b addr=%h", cyc, bus2.bram_en, bus2.bram_addr, exp_en, exp_addr);
         end
         tests_run++;
         if (bus2.out_valid !== exp_ov || bus2.fill_done !== (cyc == 6)) begin
            tests_failed++;
            $display("[TB] FAIL small_beat_c%0d: got valid=%b done=%b expected valid=%b done=%b", cyc, bus2.out_valid, bus2.fill_done, exp_ov, (cyc == 6));
         end
         if (exp_ov) begin
            tests_run++;
            if (bus2.out_data !== 32'h48 + 32'(cyc - 3)) begin
               tests_failed++;
               $display("[TB] FAIL small_data_c%0d: got %h expected %h", cyc, bus2.out_data, 32'h48 + 32'(cyc - 3));
            end
         end
         tests_run++;
         if (bus2.busy !== (cyc <= 6) || bus2.req_ready !== (cyc >= 7)) begin
            tests_failed++;
            $display("[TB] FAIL small_status_c%0d: got busy=%b ready=%b expected busy=%b ready=%b", cyc, bus2.busy, bus2.req_ready, (cyc <= 6), (cyc >= 7));
         end
      end
   endtask

   initial begin
      test_reset();
      test_line_fill(32'h0000_0120, CWF, 32'h48, "aligned");
      test_line_fill(32'h0000_0138, CWF, CWF ? 32'h4E : 32'h48, "critical");
      test_back_to_back();
      test_reset_mid_burst();
      test_line_fill(32'h0000_0120, CWF, 32'h48, "after_reset");
      test_small_config();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
